// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC conversion sequencer: FSM encoding,
// default widths and a saturating-increment helper.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int CODE_W_DEFAULT = 13;
    localparam int OVF_W          = 8;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] value);
        return (&value) ? value : value + OVF_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read port, synchronous reset and flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk_p1_delay,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Zero while empty so the data bus is defined straight out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_p1_delay) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk_p1_delay) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/adc_conv_seq.sv
// Capture sequencer for the thermometer-to-binary pipeline: enables the pipe,
// waits out its fill latency, then streams n_samples codes through a FIFO.
module adc_conv_seq
    import adc_seq_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEFAULT,
    parameter int PIPE_LAT   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_p1_delay,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic [CODE_W-1:0] code_in,
    output logic              pipe_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [OVF_W-1:0]  ovf_cnt
);

    localparam int FILL_W = $clog2(PIPE_LAT) + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [FILL_W-1:0] fill_cnt;

    logic              push;
    logic              pop;
    logic              drop;
    logic              flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [CODE_W:0]   fifo_rd;
    logic              push_last;

    assign pop       = out_valid & out_ready;
    assign push_last = (cnt == CNT_W'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_next = state;
        push       = 1'b0;
        drop       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (n_samples == '0) ? DONE : FILL;
            end
            FILL: begin
                // fill_cnt reaches zero on the same edge the FSM enters RUN (PIPE_LAT >= 2).
                if (abort) begin
                    flush      = 1'b1;
                    state_next = DONE;
                end else if (fill_cnt == FILL_W'(1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = DONE;
                end else begin
                    if (!fifo_full || pop) push = 1'b1;
                    else                   drop = 1'b1;
                    if (cnt == CNT_W'(1)) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = DONE;
                end else if (fifo_count == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_p1_delay) begin
        // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            fill_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                cnt      <= n_samples;
                fill_cnt <= FILL_W'(PIPE_LAT - 1);
                ovf_cnt  <= '0;
            end
            if (state == FILL && fill_cnt != '0) fill_cnt <= fill_cnt - FILL_W'(1);
            if (state == RUN && cnt != '0)       cnt      <= cnt - CNT_W'(1);
            if (drop)                            ovf_cnt  <= sat_inc(ovf_cnt);
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_p1_delay (clk_p1_delay),
        .rst          (rst),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .wr_data      ({push_last, code_in}),
        .rd_data      (fifo_rd),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_rd[CODE_W-1:0];
    assign out_last  = fifo_rd[CODE_W];
    assign pipe_en   = (state == FILL) || (state == RUN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_adc_conv_seq.sv
// Self-checking bench for adc_conv_seq: table of directed captures, reset corner
// sequences, and randomized captures against a queue-based reference model.
module tb_adc_conv_seq;

    localparam int L     = 6;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam logic [12:0] BASE = 13'h100;

    logic        clk_p1_delay = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] n_samples;
    logic [12:0] code_in;
    logic        pipe_en;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [7:0]  ovf_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        last;
        logic [12:0] code;
    } word_t;

    typedef struct {
        int n;
        int mode;
        int abort_at;
        int exp_words;
        int exp_ovf;
        int exp_last;
        int exp_first;
    } vec_t;

    adc_conv_seq dut (
        .clk_p1_delay (clk_p1_delay),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .n_samples    (n_samples),
        .code_in      (code_in),
        .pipe_en      (pipe_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clk_p1_delay = ~clk_p1_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pipe_en"},   32'(pipe_en),   0);
        check({tag, " out_valid"}, 32'(out_valid), 0);
        check({tag, " out_data"},  32'(out_data),  0);
        check({tag, " out_last"},  32'(out_last),  0);
        check({tag, " busy"},      32'(busy),      0);
        check({tag, " done"},      32'(done),      0);
        check({tag, " ovf_cnt"},   32'(ovf_cnt),   0);
    endtask

    // 0: always ready, 1: stalled through capture, 2: alternating, else random.
    function automatic logic ready_for(input int mode, input int k, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return k >= L + n;
            2:       return (k % 2) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // Edge 0 is the start edge; codes present before edge k are base+k.
    // Captures happen at edges L .. L+n-1; the last one carries the last flag.
    task automatic run_case(input int id, input int n, input int mode, input int a,
                            input logic [12:0] base, output int words,
                            output int last_seen, output int first_word);
        word_t q[$];
        int    m_ovf     = 0;
        int    e_last    = L + n - 1;
        int    done_edge = (n == 0) ? 0 : -1;
        logic  pop;
        string tag;
        words = 0;
        last_seen = 0;
        first_word = -1;
        for (int k = 0; ; k++) begin
            start     = (k == 0) ||
                        ((k == 2 || k == L + 1) && n > 0 && k <= e_last && (a < 1 || k <= a));
            n_samples = (k == 0) ? CNT_W'(n) : 16'd7;
            code_in   = base + 13'(k);
            abort     = (k == a);
            out_ready = ready_for(mode, k, n);

            if (out_valid && out_ready) begin
                words++;
                if (first_word < 0) first_word = int'(out_data);
                if (out_last) last_seen = 1;
            end

            pop = (q.size() > 0) && out_ready;
            if (k >= 1 && done_edge < 0) begin
                if (a >= 1 && k == a) begin
                    q.delete();
                    done_edge = k;
                end else begin
                    if (k > e_last && q.size() == 0) done_edge = k;
                    if (pop) void'(q.pop_front());
                    if (k >= L && k <= e_last) begin
                        if (q.size() < DEPTH) q.push_back('{last: (k == e_last), code: base + 13'(k)});
                        else if (m_ovf < 255) m_ovf++;
                    end
                end
            end else if (pop) begin
                void'(q.pop_front());
            end

            @(posedge clk_p1_delay);
            #1;
            tag = $sformatf("c%0d k%0d", id, k);
            check({tag, " busy"},      32'(busy),      32'((done_edge < 0) || (k <= done_edge)));
            check({tag, " done"},      32'(done),      32'(k == done_edge));
            check({tag, " pipe_en"},   32'(pipe_en),   32'(n > 0 && k <= e_last - 1 && done_edge < 0));
            check({tag, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
            check({tag, " ovf_cnt"},   32'(ovf_cnt),   32'(m_ovf));
            if (q.size() > 0) begin
                check({tag, " out_data"}, 32'(out_data), 32'(q[0].code));
                check({tag, " out_last"}, 32'(out_last), 32'(q[0].last));
            end

            if (done_edge >= 0 && k == done_edge + 1) break;
            if (k > n + L + 60) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s timeout: busy=%0d done_edge=%0d", tag, busy, done_edge);
                rst = 1'b1;
                @(posedge clk_p1_delay);
                #1;
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Start a capture and hit it with reset on edge rst_at.
    task automatic reset_during(input string tag, input int n, input logic rdy,
                                input int rst_at, input int exp_ovf_before);
        abort     = 1'b0;
        out_ready = rdy;
        n_samples = CNT_W'(n);
        for (int k = 0; k <= rst_at; k++) begin
            start   = (k == 0);
            code_in = BASE + 13'(k);
            rst     = (k == rst_at);
            if (k == rst_at) begin
                check({tag, " pre busy"},    32'(busy),    1);
                check({tag, " pre ovf_cnt"}, 32'(ovf_cnt), 32'(exp_ovf_before));
            end
            @(posedge clk_p1_delay);
            #1;
        end
        rst   = 1'b0;
        start = 1'b0;
        check_reset_values(tag);
    endtask

    initial begin
        vec_t vecs [13];
        int   words;
        int   last_seen;
        int   first_word;
        int   n;
        int   mode;
        int   a;

        vecs[0]  = '{3,   0, -1, 3,  0,   1, 'h106};
        vecs[1]  = '{0,   0, -1, 0,  0,   0, -1};
        vecs[2]  = '{8,   1, -1, 4,  4,   0, 'h106};
        vecs[3]  = '{4,   2, -1, 4,  0,   1, 'h106};
        vecs[4]  = '{100, 0, 16, 10, 0,   0, 'h106};
        vecs[5]  = '{2,   0, -1, 2,  0,   1, 'h106};
        vecs[6]  = '{1,   0, -1, 1,  0,   1, 'h106};
        vecs[7]  = '{4,   1, -1, 4,  0,   1, 'h106};
        vecs[8]  = '{5,   1, -1, 4,  1,   0, 'h106};
        vecs[9]  = '{5,   0, 3,  0,  0,   0, -1};
        vecs[10] = '{4,   1, 10, 1,  0,   0, 'h106};
        vecs[11] = '{2,   0, 0,  2,  0,   1, 'h106};
        vecs[12] = '{300, 1, -1, 4,  255, 0, 'h106};

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        n_samples = '0;
        code_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk_p1_delay);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk_p1_delay);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_case(i, vecs[i].n, vecs[i].mode, vecs[i].abort_at, BASE, words, last_seen, first_word);
            check($sformatf("v%0d words", i),   32'(words),     32'(vecs[i].exp_words));
            check($sformatf("v%0d ovf", i),     32'(ovf_cnt),   32'(vecs[i].exp_ovf));
            check($sformatf("v%0d last", i),    32'(last_seen), 32'(vecs[i].exp_last));
            check($sformatf("v%0d first", i),   32'(first_word), 32'(vecs[i].exp_first));
        end

        reset_during("rst fill", 5, 1'b1, 3, 0);
        reset_during("rst drain", 6, 1'b0, L + 6 + 1, 2);
        run_case(50, 3, 0, -1, BASE, words, last_seen, first_word);
        check("after rst words", 32'(words),      3);
        check("after rst last",  32'(last_seen),  1);
        check("after rst first", 32'(first_word), 'h106);

        for (int r = 0; r < 25; r++) begin
            n    = $urandom_range(1, 12);
            mode = $urandom_range(0, 3);
            a    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L + n - 1) : -1;
            run_case(100 + r, n, mode, a, 13'($urandom_range(0, 8191)), words, last_seen, first_word);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
